// File: rtl/raw8_quad_packer.sv
// RAW8 1-pixel/cycle to 32-bit word packer with absolute x/y tagging, crop-window write enable
// and frame-buffer index rotation that skips the buffer being displayed.
module raw8_quad_packer #(
    parameter int unsigned FRAME_NUM = 3
) (
    input  logic        p_clk,
    input  logic        rst,
    input  logic [11:0] x_start,
    input  logic [11:0] x_win,
    input  logic [11:0] y_start,
    input  logic [11:0] y_win,
    input  logic        in_vs,
    input  logic        in_hs,
    input  logic        in_de,
    input  logic [7:0]  in_pix,
    input  logic [2:0]  rd_frame_cnt,
    output logic [11:0] out_x_wr,
    output logic [11:0] out_y_wr,
    output logic        out_wr_en,
    output logic        out_hs,
    output logic [2:0]  out_frame_cnt,
    output logic [7:0]  out_wr_00,
    output logic [7:0]  out_wr_01,
    output logic [7:0]  out_wr_10,
    output logic [7:0]  out_wr_11,
    output logic        out_frame_done,
    output logic [2:0]  out_done_frame,
    output logic        out_len_err
);

    typedef enum logic [1:0] {StWaitVs, StWaitLine, StActive} state_e;

    localparam logic [3:0] FNum = 4'(FRAME_NUM);

    function automatic logic [2:0] frame_next(input logic [2:0] cur, input logic [2:0] rd);
        logic [3:0] n1;
        logic [3:0] n2;
        n1 = {1'b0, cur} + 4'd1;
        if (n1 >= FNum) n1 = n1 - FNum;
        n2 = n1 + 4'd1;
        if (n2 >= FNum) n2 = n2 - FNum;
        return (n1[2:0] == rd) ? n2[2:0] : n1[2:0];
    endfunction

    state_e      state_q, state_d;
    logic        vs_q;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        x_sat_q, x_sat_d;
    logic [2:0]  frame_q, frame_d;
    logic [7:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic        err_q, err_d;
    logic        done_d;
    logic [2:0]  done_frame_q, done_frame_d;

    logic [11:0] x_wr_q, y_wr_q;
    logic        wr_en_q, hs_q, done_q;
    logic [7:0]  w0_q, w1_q, w2_q, w3_q;

    logic        vs_rise;
    logic        pix_take;
    logic [11:0] pix_x;
    logic        emit, emit_sat, in_win, wr_go;
    logic [11:0] emit_x, x_lo;
    logic [12:0] x_end, y_end;
    logic [7:0]  e0, e1, e2, e3;
    logic        pending;

    assign vs_rise = in_vs & ~vs_q;
    assign pending = (x_q[1:0] != 2'd0) && !x_sat_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        x_sat_d      = x_sat_q;
        y_d          = y_q;
        frame_d      = frame_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        err_d        = err_q;
        done_d       = 1'b0;
        done_frame_d = done_frame_q;
        pix_take     = 1'b0;
        pix_x        = 12'd0;
        emit         = 1'b0;
        emit_sat     = 1'b0;
        emit_x       = {x_q[11:2], 2'b00};
        e0           = p0_q;
        e1           = p1_q;
        e2           = p2_q;
        e3           = 8'd0;

        unique case (state_q)
            StWaitVs: begin
                if (vs_rise) begin
                    state_d = StWaitLine;
                    x_d     = 12'd0;
                    x_sat_d = 1'b0;
                    y_d     = 12'd0;
                end
            end
            StWaitLine: begin
                if (vs_rise) begin
                    frame_d      = frame_next(frame_q, rd_frame_cnt);
                    done_d       = 1'b1;
                    done_frame_d = frame_q;
                    x_d          = 12'd0;
                    x_sat_d      = 1'b0;
                    y_d          = 12'd0;
                end
                if (in_de) begin
                    pix_take = 1'b1;
                    state_d  = StActive;
                end
            end
            StActive: begin
                if (vs_rise) begin
                    // Mid-line frame start: pending lanes are dropped, not flushed.
                    frame_d      = frame_next(frame_q, rd_frame_cnt);
                    done_d       = 1'b1;
                    done_frame_d = frame_q;
                    x_d          = 12'd0;
                    x_sat_d      = 1'b0;
                    y_d          = 12'd0;
                    state_d      = StWaitLine;
                    if (in_de || pending) err_d = 1'b1;
                end else if (!in_de) begin
                    state_d = StWaitLine;
                    x_d     = 12'd0;
                    x_sat_d = 1'b0;
                    if (y_q != 12'hFFF) y_d = y_q + 12'd1;
                    if (pending) begin
                        emit  = 1'b1;
                        err_d = 1'b1;
                    end
                end else if (!x_sat_q) begin
                    pix_take = 1'b1;
                    pix_x    = x_q;
                end
            end
            default: state_d = StWaitVs;
        endcase

        if (pix_take) begin
            if (pix_x == 12'hFFF) x_sat_d = 1'b1;
            else                  x_d     = pix_x + 12'd1;
            unique case (pix_x[1:0])
                2'd0: begin
                    p0_d = in_pix;
                    p1_d = 8'd0;
                    p2_d = 8'd0;
                end
                2'd1: p1_d = in_pix;
                2'd2: p2_d = in_pix;
                default: begin
                    emit     = 1'b1;
                    emit_sat = (pix_x == 12'hFFF);
                    emit_x   = {pix_x[11:2], 2'b00};
                    e3       = in_pix;
                end
            endcase
        end
    end

    // 13-bit window ends so start + size never wraps.
    assign x_lo   = x_start & 12'hFFC;
    assign x_end  = {1'b0, x_lo} + {1'b0, x_win};
    assign y_end  = {1'b0, y_start} + {1'b0, y_win};
    assign in_win = (emit_x >= x_lo) && ({1'b0, emit_x} < x_end) &&
                    (y_q >= y_start) && ({1'b0, y_q} < y_end);
    assign wr_go  = emit && in_win && !emit_sat && (y_q != 12'hFFF);

    always_ff @(posedge p_clk) begin
        if (rst) begin
            state_q      <= StWaitVs;
            vs_q         <= 1'b0;
            x_q          <= 12'd0;
            x_sat_q      <= 1'b0;
            y_q          <= 12'd0;
            frame_q      <= 3'd0;
            p0_q         <= 8'd0;
            p1_q         <= 8'd0;
            p2_q         <= 8'd0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            done_frame_q <= 3'd0;
            wr_en_q      <= 1'b0;
            hs_q         <= 1'b0;
            x_wr_q       <= 12'd0;
            y_wr_q       <= 12'd0;
            w0_q         <= 8'd0;
            w1_q         <= 8'd0;
            w2_q         <= 8'd0;
            w3_q         <= 8'd0;
        end else begin
            state_q      <= state_d;
            vs_q         <= in_vs;
            x_q          <= x_d;
            x_sat_q      <= x_sat_d;
            y_q          <= y_d;
            frame_q      <= frame_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            err_q        <= err_d;
            done_q       <= done_d;
            done_frame_q <= done_frame_d;
            wr_en_q      <= wr_go;
            hs_q         <= in_hs;
            if (wr_go) begin
                x_wr_q <= emit_x;
                y_wr_q <= y_q;
                w0_q   <= e0;
                w1_q   <= e1;
                w2_q   <= e2;
                w3_q   <= e3;
            end
        end
    end

    assign out_x_wr       = x_wr_q;
    assign out_y_wr       = y_wr_q;
    assign out_wr_en      = wr_en_q;
    assign out_hs         = hs_q;
    assign out_frame_cnt  = frame_q;
    assign out_wr_00      = w0_q;
    assign out_wr_01      = w1_q;
    assign out_wr_10      = w2_q;
    assign out_wr_11      = w3_q;
    assign out_frame_done = done_q;
    assign out_done_frame = done_frame_q;
    assign out_len_err    = err_q;

endmodule
